pc_fetch_unit: RTL and testbench

Instruction-fetch front end of the pipelined RV32 core. Holds the program counter, forms PC+4 through the existing `adder`, and issues one word-aligned request at a time to instruction memory. Returned instructions are buffered in a small in-order queue that feeds decode over a valid/ready handshake. Branch, jump and trap redirects from execute flush the queue and discard stale responses.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/adder.sv | 12 +
 rtl/fetch_queue.sv | 72 +++++++
 rtl/pc_fetch_unit.sv | 128 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM state encoding,
// the fetch-queue entry layout and the instruction size.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/adder.sv
// Plain modular adder shared by the datapath; the sum wraps at 2^WIDTH.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_queue.sv
// In-order circular FIFO of fetched instructions with flush and occupancy.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     do_pop;

    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];
    assign do_pop = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: owns the PC, issues one outstanding request to instruction
// memory, queues returned words for decode and handles redirect flushes.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      tag_q, tag_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      redirect_target;
    logic             granted;
    logic             push;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign imem_addr       = pc_q;
    assign granted         = imem_req && imem_gnt;
    assign push_entry      = '{instr: imem_rdata, pc: tag_q};

    adder #(.WIDTH(32)) u_pc_adder (
        .a   (pc_q),
        .b   (32'(INSTR_BYTES)),
        .sum (pc_plus4)
    );

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (out_valid && out_ready),
        .flush      (redirect_valid),
        .head       (head),
        .empty      (q_empty),
        .count      (q_count)
    );

    // Head fields read as zero when empty so decode never sees stale storage.
    assign out_valid = !q_empty;
    assign out_instr = out_valid ? head.instr : 32'h0;
    assign out_pc    = out_valid ? head.pc : 32'h0;

    adder #(.WIDTH(32)) u_head_adder (
        .a   (out_pc),
        .b   (32'(INSTR_BYTES)),
        .sum (out_pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
        end
    end

    // Redirect wins everywhere; a response still in flight is marked stale.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        push    = 1'b0;
        if (granted) begin
            tag_d = pc_q;
            pc_d  = pc_plus4;
        end
        if (redirect_valid) begin
            pc_d = redirect_target;
        end
        unique case (state_q)
            REQ: begin
                if (granted) begin
                    state_d = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push    = !redirect_valid;
                    state_d = REQ;
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        if (reset_n && (state_q == REQ) && (q_count != CNT_W'(DEPTH))) begin
            imem_req = 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a queue of hand-computed expected entries
// is drained by a monitor on every accepted output; a second wrap-around DUT.
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        imem_gnt_w;
    logic        imem_rvalid_w;
    logic [31:0] imem_rdata_w;
    logic        redirect_valid_w;
    logic [31:0] redirect_pc_w;
    logic        out_valid_w;
    logic        out_ready_w;
    logic [31:0] out_instr_w;
    logic [31:0] out_pc_w;
    logic [31:0] out_pc_plus4_w;

    int   checks;
    int   errors;
    int   mem_k;
    bit   drop_on_reset;
    int   grant_cnt;
    int   g0;
    exp_t sb_q[$];

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req_w),
        .imem_addr      (imem_addr_w),
        .imem_gnt       (imem_gnt_w),
        .imem_rvalid    (imem_rvalid_w),
        .imem_rdata     (imem_rdata_w),
        .redirect_valid (redirect_valid_w),
        .redirect_pc    (redirect_pc_w),
        .out_valid      (out_valid_w),
        .out_ready      (out_ready_w),
        .out_instr      (out_instr_w),
        .out_pc         (out_pc_w),
        .out_pc_plus4   (out_pc_plus4_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst_n, input logic gnt, input logic ready,
                                 input logic rv, input logic [31:0] rpc);
        reset_n        = rst_n;
        imem_gnt       = gnt;
        out_ready      = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic expect_entry(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] pc4);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.pc4   = pc4;
        sb_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        drop_on_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
    endtask

    // Main memory model: response data equals the word address, k cycles after grant.
    initial begin
        logic        g;
        logic [31:0] a;
        logic        rst_seen;
        int          pend;
        logic [31:0] pend_addr;
        pend        = 0;
        pend_addr   = 32'h0;
        grant_cnt   = 0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            g        = imem_req && imem_gnt;
            a        = imem_addr;
            rst_seen = !reset_n;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (rst_seen && drop_on_reset) begin
                pend = 0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pend_addr;
                end
            end
            if (g) begin
                grant_cnt++;
                if (mem_k <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = a;
                end else begin
                    pend      = mem_k - 1;
                    pend_addr = a;
                end
            end
        end
    end

    initial begin
        logic        g2;
        logic [31:0] a2;
        imem_gnt_w       = 1'b1;
        out_ready_w      = 1'b1;
        redirect_valid_w = 1'b0;
        redirect_pc_w    = 32'h0;
        imem_rvalid_w    = 1'b0;
        imem_rdata_w     = 32'h0;
        forever begin
            @(negedge clk);
            g2 = imem_req_w && imem_gnt_w;
            a2 = imem_addr_w;
            @(posedge clk);
            #1;
            imem_rvalid_w = g2;
            imem_rdata_w  = a2;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output actual pc=%h instr=%h expected none at %0t",
                             out_pc, out_instr, $time);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_instr", out_instr, e.instr);
                    checkOutput("sb_pc", out_pc, e.pc);
                    checkOutput("sb_pc_plus4", out_pc_plus4, e.pc4);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        mem_k  = 1;
        drop_on_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

        // Reset state, first fetches with k=1, and the wrap-around instance.
        do_reset();
        @(negedge clk);
        checkOutput("rst_imem_req", imem_req, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_pc_plus4", out_pc_plus4, 32'h4);
        expect_entry(32'h0, 32'h0, 32'h4);
        expect_entry(32'h4, 32'h4, 32'h8);
        next_cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("first_req", imem_req, 1'b1);
        checkOutput("first_addr", imem_addr, 32'h0);
        checkOutput("wrap_first_addr", imem_addr_w, 32'hFFFF_FFFC);
        next_cycle();
        @(negedge clk);
        checkOutput("c1_out_valid", out_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        checkOutput("c2_out_valid", out_valid, 1'b1);
        checkOutput("c2_req", imem_req, 1'b1);
        checkOutput("c2_addr", imem_addr, 32'h4);
        checkOutput("wrap_out_valid", out_valid_w, 1'b1);
        checkOutput("wrap_out_pc", out_pc_w, 32'hFFFF_FFFC);
        checkOutput("wrap_out_pc_plus4", out_pc_plus4_w, 32'h0);
        checkOutput("wrap_second_addr", imem_addr_w, 32'h0);
        next_cycle();
        @(negedge clk);
        checkOutput("c3_out_valid", out_valid, 1'b0);
        next_cycle();
        imem_gnt = 1'b0;
        @(negedge clk);
        checkOutput("c4_out_valid", out_valid, 1'b1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        checkOutput("t1_drained", sb_q.size(), 32'd0);

        // Backpressure: queue fills after two grants, then drains in order.
        do_reset();
        expect_entry(32'h0, 32'h0, 32'h4);
        expect_entry(32'h4, 32'h4, 32'h8);
        g0 = grant_cnt;
        next_cycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (9) next_cycle();
        @(negedge clk);
        checkOutput("bp_grants", 32'(grant_cnt - g0), 32'd2);
        checkOutput("bp_req_idle", imem_req, 1'b0);
        checkOutput("bp_out_valid", out_valid, 1'b1);
        next_cycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        checkOutput("bp_empty", out_valid, 1'b0);
        checkOutput("t2_drained", sb_q.size(), 32'd0);

        // Redirect in WAIT with k=3: late response discarded.
        do_reset();
        mem_k = 3;
        expect_entry(32'h100, 32'h100, 32'h104);
        next_cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        next_cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        next_cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("wr_drop_req", imem_req, 1'b0);
        checkOutput("wr_out_valid", out_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        checkOutput("wr_drop_req2", imem_req, 1'b0);
        next_cycle();
        @(negedge clk);
        checkOutput("wr_req", imem_req, 1'b1);
        checkOutput("wr_addr", imem_addr, 32'h100);
        checkOutput("wr_c4_out_valid", out_valid, 1'b0);
        repeat (3) next_cycle();
        @(negedge clk);
        checkOutput("wr_c7_out_valid", out_valid, 1'b0);
        next_cycle();
        imem_gnt = 1'b0;
        @(negedge clk);
        checkOutput("wr_c8_out_pc", out_pc, 32'h100);
        next_cycle();
        @(negedge clk);
        checkOutput("t3_drained", sb_q.size(), 32'd0);

        // Redirect coincident with the grant for address 8.
        do_reset();
        mem_k = 1;
        expect_entry(32'h0, 32'h0, 32'h4);
        expect_entry(32'h4, 32'h4, 32'h8);
        expect_entry(32'h200, 32'h200, 32'h204);
        next_cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        repeat (4) next_cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        @(negedge clk);
        checkOutput("rg_req", imem_req, 1'b1);
        checkOutput("rg_addr", imem_addr, 32'h8);
        next_cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("rg_flush_valid", out_valid, 1'b0);
        checkOutput("rg_drop_req", imem_req, 1'b0);
        next_cycle();
        @(negedge clk);
        checkOutput("rg_resume_req", imem_req, 1'b1);
        checkOutput("rg_resume_addr", imem_addr, 32'h200);
        next_cycle();
        next_cycle();
        imem_gnt = 1'b0;
        @(negedge clk);
        checkOutput("rg_out_pc", out_pc, 32'h200);
        next_cycle();
        @(negedge clk);
        checkOutput("t4_drained", sb_q.size(), 32'd0);

        // One-cycle reset while WAIT; the in-flight response must be ignored.
        do_reset();
        mem_k = 3;
        drop_on_reset = 1'b0;
        expect_entry(32'h0, 32'h0, 32'h4);
        next_cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("mr_req_in_reset", imem_req, 1'b0);
        next_cycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("mr_req", imem_req, 1'b1);
        checkOutput("mr_addr", imem_addr, 32'h0);
        checkOutput("mr_c2_out_valid", out_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        checkOutput("mr_c3_out_valid", out_valid, 1'b0);
        next_cycle();
        imem_gnt = 1'b1;
        @(negedge clk);
        checkOutput("mr_c4_out_valid", out_valid, 1'b0);
        checkOutput("mr_c4_addr", imem_addr, 32'h0);
        repeat (3) next_cycle();
        @(negedge clk);
        checkOutput("mr_c7_out_valid", out_valid, 1'b0);
        next_cycle();
        imem_gnt = 1'b0;
        @(negedge clk);
        checkOutput("mr_c8_out_valid", out_valid, 1'b1);
        next_cycle();
        @(negedge clk);
        checkOutput("t6_drained", sb_q.size(), 32'd0);
        drop_on_reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
